// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the sync FIFO and its burst read controller.
//   FIFO_DATA_WIDTH : default word width, shared with the FIFO itself
//   RD_BUF_DEPTH    : number of entries in the reader's output buffer
//   rd_state_e      : read controller states (IDLE, RUN, DONE)
//   next_buf_cnt()  : occupancy update for the output buffer
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 32;

  // Two entries let the sink stall for a cycle without losing the word that
  // was already requested from the FIFO, while still allowing 1 word/cycle.
  localparam logic [2:0] RD_BUF_DEPTH = 3'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rd_state_e;

  // Push and pop in the same cycle leave the occupancy unchanged.
  function automatic logic [1:0] next_buf_cnt(input logic [1:0] cnt,
                                              input logic       push,
                                              input logic       pop);
    logic [1:0] res;
    res = cnt;
    if (push && !pop) begin
      res = cnt + 2'd1;
    end else if (pop && !push) begin
      res = cnt - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// ---------------------------------------------------------------------------
// fifo_rd_skid
// Two-entry in-order output buffer for the FIFO burst reader. Entry 0 is
// always the head of the stream.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data into the buffer this cycle
//   push_data  : word to store
//   pop        : remove the head word this cycle (ignored when empty)
//   head_data  : current head word
//   buf_cnt    : number of valid entries (0..2)
// ---------------------------------------------------------------------------
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [1:0]            buf_cnt
);

  logic [DATA_WIDTH-1:0] ent0_q, ent0_d;
  logic [DATA_WIDTH-1:0] ent1_q, ent1_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  pop_ok;
  logic                  push_ok;
  logic                  wr_slot1;

  // Next-state of the buffer. A pop shifts entry 1 into entry 0; the pushed
  // word then lands in the first slot that is free after that shift. A push
  // into a full buffer without a pop is dropped (the controller never
  // requests one).
  always_comb begin
    ent0_d   = ent0_q;
    ent1_d   = ent1_q;
    pop_ok   = pop && (cnt_q != 2'd0);
    push_ok  = push && ((cnt_q != 2'd2) || pop_ok);
    wr_slot1 = (cnt_q == 2'd2) || ((cnt_q == 2'd1) && !pop_ok);

    if (pop_ok) begin
      ent0_d = ent1_q;
    end
    if (push_ok) begin
      if (wr_slot1) begin
        ent1_d = push_data;
      end else begin
        ent0_d = push_data;
      end
    end
    cnt_d = next_buf_cnt(cnt_q, push_ok, pop_ok);
  end

  // Buffer storage and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head_data = ent0_q;
  assign buf_cnt   = cnt_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// ---------------------------------------------------------------------------
// fifo_burst_reader
// Read-side controller for the standard-mode sync FIFO (data valid the cycle
// after fifo_rd_en). On start it drains exactly burst_len words and presents
// them as a valid/ready stream with a last marker, through a 2-entry buffer so
// the sink can stall without dropping words.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   start         : burst request, sampled only while idle
//   burst_len     : words to transfer, sampled with start (0 = no reads)
//   busy          : high while running or completing a burst
//   done          : one-cycle pulse when the burst completes
//   fifo_rd_en    : FIFO read strobe
//   fifo_data     : FIFO read data, valid the cycle after fifo_rd_en
//   fifo_empty    : FIFO empty flag
//   m_valid/m_ready/m_data/m_last : output stream
// Optional feature (macro FIFO_READER_STATS_EN):
//   stat_words    : saturating count of stream handshakes since reset
//   stat_bursts   : saturating count of completed bursts (incl. zero-length)
// ---------------------------------------------------------------------------
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  output logic                  busy,
  output logic                  done,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [31:0]           stat_words,
  output logic [15:0]           stat_bursts
`endif
);

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  rd_state_e            state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] issued_q, issued_d;
  logic [LEN_WIDTH-1:0] accepted_q, accepted_d;
  logic                 inflight_q, inflight_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [1:0]           buf_cnt;
  logic [2:0]           occ_next;
  logic                 room;
  logic                 pop;
  logic                 last_beat;
  logic                 rd_en;

  // Read issue. The buffer plus the word already in flight must still fit
  // after this cycle's pop, which makes fifo_rd_en depend combinationally on
  // m_ready; that path is what allows back-to-back reads at full rate.
  always_comb begin
    pop       = m_valid && m_ready;
    occ_next  = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, pop};
    room      = occ_next < RD_BUF_DEPTH;
    rd_en     = (state_q == RUN) && !fifo_empty && (issued_q < len_q) && room;
    last_beat = (accepted_q == (len_q - LEN_ONE));
  end

  // Controller next state. Counters are cleared when a burst is accepted and
  // cannot wrap: issued stops at len and accepted ends the burst at len-1.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    issued_d   = issued_q;
    accepted_d = accepted_q;
    inflight_d = rd_en;

    case (state_q)
      IDLE: begin
        if (start) begin
          len_d      = burst_len;
          issued_d   = '0;
          accepted_d = '0;
          state_d    = (burst_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (rd_en) begin
          issued_d = issued_q + LEN_ONE;
        end
        if (pop) begin
          accepted_d = accepted_q + LEN_ONE;
          if (last_beat) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // Controller state and registered status outputs. Reset drops the word in
  // flight by clearing inflight_q, so it is never pushed into the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
      inflight_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      accepted_q <= accepted_d;
      inflight_q <= inflight_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // The FIFO word returned for last cycle's read is pushed this cycle.
  fifo_rd_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (fifo_data),
    .pop       (pop),
    .head_data (m_data),
    .buf_cnt   (buf_cnt)
  );

  assign fifo_rd_en = rd_en;
  assign m_valid    = (buf_cnt != 2'd0);
  assign m_last     = m_valid && last_beat;
  assign busy       = busy_q;
  assign done       = done_q;

`ifdef FIFO_READER_STATS_EN
  logic [31:0] stat_words_q, stat_words_d;
  logic [15:0] stat_bursts_q, stat_bursts_d;

  // Saturating statistics. DONE is only ever entered for one cycle, so a
  // next state of DONE marks exactly one burst completion.
  always_comb begin
    stat_words_d  = stat_words_q;
    stat_bursts_d = stat_bursts_q;
    if (pop && (stat_words_q != '1)) begin
      stat_words_d = stat_words_q + 32'd1;
    end
    if ((state_d == DONE) && (state_q != DONE) && (stat_bursts_q != '1)) begin
      stat_bursts_d = stat_bursts_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_words_q  <= '0;
      stat_bursts_q <= '0;
    end else begin
      stat_words_q  <= stat_words_d;
      stat_bursts_q <= stat_bursts_d;
    end
  end

  assign stat_words  = stat_words_q;
  assign stat_bursts = stat_bursts_q;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_burst_reader
// Bench for fifo_burst_reader: a queue-based FIFO with one-cycle read latency
// feeds the reader, a reference queue holds every word written in order, and
// a monitor checks stream data, ordering, stall stability and last/done.
// ---------------------------------------------------------------------------
module tb_fifo_burst_reader;

  localparam int DW = 32;
  localparam int LW = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic [LW-1:0] burst_len;
  logic          busy;
  logic          done;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_empty = 1'b1;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;

  // Bench state shared between stimulus and monitor.
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdCount, hsCount, doneCount, beatCount, curLen;
  int startCyc, firstValidCyc, firstHsCyc, lastHsCyc, doneCyc;
  bit sawValid;
  int readyMode = 0;
  logic          wrEn = 1'b0;
  logic [DW-1:0] wrData = '0;
  logic [DW-1:0] fifoQ[$];
  logic [DW-1:0] refQ[$];

  typedef struct {
    int len;
    int mode;
    int preload;
    int base;
    int expRd;
    int expHs;
    int expValidLat;
    int expDoneLat;
    int expSpan;
  } vec_t;

  vec_t vecs[5];

  fifo_burst_reader #(
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .burst_len  (burst_len),
    .busy       (busy),
    .done       (done),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Standard-mode sync FIFO: read data appears the cycle after the read
  // strobe, empty flag is registered.
  always @(posedge clk) begin
    if (fifo_rd_en && (fifoQ.size() > 0)) begin
      fifo_data <= fifoQ.pop_front();
    end
    if (wrEn) begin
      fifoQ.push_back(wrData);
    end
    fifo_empty <= (fifoQ.size() == 0);
  end

  // Sink ready pattern: 0 always ready, 1 ready one cycle in three,
  // 2 random, otherwise never ready.
  initial begin
    int phase;
    phase = 0;
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0: m_ready = 1'b1;
        1: m_ready = ((phase % 3) == 0);
        2: m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b0;
      endcase
      phase++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeWord(input logic [DW-1:0] w);
    wrEn   = 1'b1;
    wrData = w;
    refQ.push_back(w);
    tick();
    wrEn = 1'b0;
  endtask

  task automatic clearCounters(input int len);
    rdCount   = 0;
    hsCount   = 0;
    doneCount = 0;
    beatCount = 0;
    curLen    = len;
    sawValid  = 1'b0;
    firstValidCyc = -1;
    firstHsCyc = -1;
    lastHsCyc  = -1;
    doneCyc    = -1;
  endtask

  // Pulse start for one cycle; startCyc is the cycle count at the sampling edge.
  task automatic applyStimulus(input int len);
    burst_len = LW'(len);
    start     = 1'b1;
    tick();
    startCyc  = cyc;
    start     = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n;
    n = 0;
    while ((doneCount == 0) && (n < budget)) begin
      tick();
      n++;
    end
    checkOutput("done_seen", 32'(doneCount != 0), 32'd1);
  endtask

  task automatic doBurst(input int len, input int mode, input int budget);
    readyMode = mode;
    clearCounters(len);
    applyStimulus(len);
    waitDone(budget);
    checkOutput("rd_count", rdCount, len);
    checkOutput("hs_count", hsCount, len);
    checkOutput("done_once", doneCount, 1);
    checkOutput("busy_after", busy, 1'b0);
  endtask

  // Stream monitor, sampling on the falling edge.
  initial begin
    logic          prevValid, prevReady, prevLast;
    logic [DW-1:0] prevData;
    prevValid = 1'b0;
    prevReady = 1'b0;
    prevLast  = 1'b0;
    prevData  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prevValid = 1'b0;
        prevReady = 1'b0;
      end else begin
        if (prevValid && !prevReady) begin
          checkOutput("stall_valid_hold", m_valid, 1'b1);
          checkOutput("stall_data_hold", m_data, prevData);
          checkOutput("stall_last_hold", m_last, prevLast);
        end
        if (fifo_rd_en) begin
          rdCount++;
          checkOutput("rd_while_empty", fifo_empty, 1'b0);
        end
        if (m_valid && !sawValid) begin
          sawValid = 1'b1;
          firstValidCyc = cyc;
        end
        if (m_valid && m_ready) begin
          checks++;
          if (refQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL extra_word actual=%0h expected=none", m_data);
          end else if (m_data !== refQ[0]) begin
            errors++;
            $display("[TB] FAIL data actual=%0h expected=%0h", m_data, refQ[0]);
            void'(refQ.pop_front());
          end else begin
            void'(refQ.pop_front());
          end
          checkOutput("last", m_last, 32'(beatCount == curLen - 1));
          if (hsCount == 0) firstHsCyc = cyc;
          lastHsCyc = cyc;
          beatCount++;
          hsCount++;
        end
        if (done) begin
          doneCount++;
          doneCyc = cyc;
        end
        prevValid = m_valid;
        prevReady = m_ready;
        prevData  = m_data;
        prevLast  = m_last;
      end
    end
  end

  // Global watchdog so the run can never hang.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int len;
    rst       = 1'b1;
    start     = 1'b0;
    burst_len = '0;
    clearCounters(0);

    // Reset state.
    repeat (3) tick();
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_rd_en", fifo_rd_en, 1'b0);
    checkOutput("rst_m_valid", m_valid, 1'b0);
    checkOutput("rst_m_data", m_data, 32'd0);
    checkOutput("rst_m_last", m_last, 1'b0);
    rst = 1'b0;
    tick();

    // len, mode, preload, base, expRd, expHs, expValidLat, expDoneLat, expSpan
    vecs[0] = '{8, 0, 8, 'h10, 8, 8, 3, 11, 7};
    vecs[1] = '{0, 0, 0, 'h00, 0, 0, -1, 1, -1};
    vecs[2] = '{4, 1, 4, 'h40, 4, 4, -1, -1, -1};
    vecs[3] = '{1, 0, 1, 'h80, 1, 1, 3, 4, 0};
    vecs[4] = '{5, 2, 5, 'hA0, 5, 5, -1, -1, -1};

    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < vecs[i].preload; k++) writeWord(DW'(vecs[i].base + k));
      repeat (2) tick();
      readyMode = vecs[i].mode;
      clearCounters(vecs[i].len);
      applyStimulus(vecs[i].len);
      waitDone(300);
      checkOutput("vec_rd_count", rdCount, vecs[i].expRd);
      checkOutput("vec_hs_count", hsCount, vecs[i].expHs);
      checkOutput("vec_done_once", doneCount, 1);
      checkOutput("vec_busy_after", busy, 1'b0);
      if (vecs[i].expValidLat >= 0)
        checkOutput("valid_latency", firstValidCyc - startCyc, vecs[i].expValidLat);
      if (vecs[i].expDoneLat >= 0)
        checkOutput("done_latency", doneCyc - startCyc, vecs[i].expDoneLat);
      if (vecs[i].expSpan >= 0)
        checkOutput("hs_span", lastHsCyc - firstHsCyc, vecs[i].expSpan);
      if (vecs[i].len == 0)
        checkOutput("zero_len_no_valid", sawValid, 1'b0);
      tick();
    end

    // Empty FIFO at start, words trickle in at 5-cycle gaps.
    readyMode = 0;
    clearCounters(3);
    applyStimulus(3);
    checkOutput("busy_running", busy, 1'b1);
    for (int k = 0; k < 3; k++) begin
      repeat (4) tick();
      writeWord(DW'('hC0 + k));
    end
    waitDone(100);
    checkOutput("trickle_rd_count", rdCount, 3);
    checkOutput("trickle_hs_count", hsCount, 3);
    checkOutput("trickle_done_after_last", doneCyc - lastHsCyc, 1);
    tick();

    // Start pulsed during RUN must be ignored.
    for (int k = 0; k < 8; k++) writeWord(DW'('hD0 + k));
    repeat (2) tick();
    readyMode = 2;
    clearCounters(6);
    applyStimulus(6);
    tick();
    burst_len = LW'(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    waitDone(300);
    checkOutput("restart_hs_count", hsCount, 6);
    checkOutput("restart_rd_count", rdCount, 6);
    checkOutput("restart_done_once", doneCount, 1);
    checkOutput("restart_fifo_left", fifoQ.size(), 2);
    tick();
    doBurst(2, 0, 100);
    tick();

    // Reset during RUN with a read in flight.
    for (int k = 0; k < 4; k++) writeWord(DW'('hE0 + k));
    repeat (2) tick();
    readyMode = 3;
    clearCounters(4);
    applyStimulus(4);
    tick();
    checkOutput("rd_before_rst", fifo_rd_en, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("arst_rd_en", fifo_rd_en, 1'b0);
    checkOutput("arst_m_valid", m_valid, 1'b0);
    checkOutput("arst_m_data", m_data, 32'd0);
    checkOutput("arst_m_last", m_last, 1'b0);
    checkOutput("arst_busy", busy, 1'b0);
    checkOutput("arst_done", done, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    refQ = fifoQ;
    tick();
    doBurst(2, 0, 100);
    tick();
    doBurst(fifoQ.size(), 0, 100);
    tick();

    // Randomized bursts against the reference queue.
    for (int r = 0; r < 10; r++) begin
      len = $urandom_range(0, 7);
      for (int k = 0; k < len; k++) writeWord($urandom);
      repeat (2) tick();
      doBurst(len, 2, 400);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
